// File: rtl/doorlock_pkg.sv
// Shared constants for the door-lock keypad controller: key codes coming
// from the switch interface, FSM state encodings and the digit helper.
package doorlock_pkg;

  // Key codes delivered by the switch interface
  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam logic [3:0] KEY_NEXT = 4'd1;
  localparam logic [3:0] KEY_INC  = 4'd2;
  localparam logic [3:0] KEY_A    = 4'd11;
  localparam logic [3:0] KEY_B    = 4'd12;

  // FSM state encodings (plain constants so legacy tools can decode them)
  localparam logic [2:0] ST_ENTRY   = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;
  localparam logic [2:0] ST_SET     = 3'd5;

  // Dwell timer width; large enough for a 10 s lockout at 125 MHz
  localparam int TIMER_W = 31;

  // Increment one BCD digit, wrapping from dmax back to 0
  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] dmax);
    return (d == dmax) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Dwell timer shared by OPEN, FAIL and LOCKOUT. Loaded with N-1 when a
// timed state is entered, it counts down to zero and holds there, so the
// owning state sees expired on its N-th cycle.
module doorlock_timer
  import doorlock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);

  logic [TIMER_W-1:0] cnt;

  // Load on request, otherwise count down and stop at zero
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours, avoiding order races.
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/doorlock_keypad_ctrl.sv
// Keypad door-lock controller. Turns the held key-code stream into single
// events, edits a BCD entry buffer, checks it against the stored password,
// and drives unlock / error / lockout plus password reprogramming.
module doorlock_keypad_ctrl
  import doorlock_pkg::*;
#(
  parameter int                  DIGITS        = 4,
  parameter int                  DIGIT_MAX     = 9,
  parameter logic [4*DIGITS-1:0] DEFAULT_PW    = '0,
  parameter int                  MAX_FAIL      = 3,
  parameter int                  UNLOCK_CYCLES = 375_000_000,
  parameter int                  ERR_CYCLES    = 125_000_000,
  parameter int                  LOCK_CYCLES   = 1_250_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   entry_bcd,
  output logic [2:0]            cursor,
  output logic                  unlock,
  output logic                  error,
  output logic                  lockout,
  output logic                  prog_mode,
  output logic                  key_ack
);

  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic [2:0]              state_q, state_d;
  logic [DIGITS-1:0][3:0]  entry_q, entry_d;
  logic [DIGITS-1:0][3:0]  pw_q, pw_d;
  logic [2:0]              cursor_q, cursor_d;
  logic [FAIL_W-1:0]       fail_q, fail_d;
  logic [3:0]              key_prev;
  logic                    evt;
  logic                    ack_d;
  logic                    clear_entry;
  logic                    tmr_load;
  logic [TIMER_W-1:0]      tmr_val;
  logic                    tmr_expired;

  // A held code produces exactly one event: only a change to a non-zero code counts
  assign evt = (key_code != KEY_NONE) && (key_code != key_prev);

  doorlock_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Next-state, edit and password decisions for the current key event
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d     = state_q;
    entry_d     = entry_q;
    cursor_d    = cursor_q;
    pw_d        = pw_q;
    fail_d      = fail_q;
    ack_d       = 1'b0;
    clear_entry = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      ST_ENTRY, ST_SET: begin
        if (evt) begin
          case (key_code)
            KEY_INC: begin
              ack_d = 1'b1;
              for (int i = 0; i < DIGITS; i++) begin
                if (3'(i) == cursor_q) entry_d[i] = bcd_inc(entry_q[i], 4'(DIGIT_MAX));
              end
            end
            KEY_NEXT: begin
              ack_d    = 1'b1;
              cursor_d = (cursor_q == 3'(DIGITS - 1)) ? 3'd0 : cursor_q + 3'd1;
            end
            KEY_A: begin
              ack_d = 1'b1;
              if (state_q == ST_ENTRY) begin
                state_d = ST_CHECK;
              end else begin
                pw_d        = entry_q;
                state_d     = ST_ENTRY;
                clear_entry = 1'b1;
              end
            end
            KEY_B: begin
              // In ENTRY this is "clear"; in SET it abandons the new password
              ack_d       = 1'b1;
              state_d     = ST_ENTRY;
              clear_entry = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_CHECK: begin
        tmr_load = 1'b1;
        if (entry_q == pw_q) begin
          state_d = ST_OPEN;
          fail_d  = '0;
          tmr_val = TIMER_W'(UNLOCK_CYCLES - 1);
        end else if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
          state_d = ST_LOCKOUT;
          tmr_val = TIMER_W'(LOCK_CYCLES - 1);
        end else begin
          state_d = ST_FAIL;
          fail_d  = fail_q + 1'b1;
          tmr_val = TIMER_W'(ERR_CYCLES - 1);
        end
      end

      ST_OPEN: begin
        // Expiry takes priority; a key arriving on that same cycle is dropped
        if (tmr_expired) begin
          state_d     = ST_ENTRY;
          clear_entry = 1'b1;
        end else if (evt && key_code == KEY_A) begin
          ack_d       = 1'b1;
          state_d     = ST_ENTRY;
          clear_entry = 1'b1;
        end else if (evt && key_code == KEY_B) begin
          ack_d       = 1'b1;
          state_d     = ST_SET;
          clear_entry = 1'b1;
        end
      end

      ST_FAIL, ST_LOCKOUT: begin
        if (tmr_expired) begin
          state_d     = ST_ENTRY;
          clear_entry = 1'b1;
          if (state_q == ST_LOCKOUT) fail_d = '0;
        end
      end

      default: begin
        state_d     = ST_ENTRY;
        clear_entry = 1'b1;
      end
    endcase

    if (clear_entry) begin
      entry_d  = '0;
      cursor_d = '0;
    end
  end

  // Register FSM state, edit buffers, password and key history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ENTRY;
      entry_q  <= '0;
      cursor_q <= '0;
      // NOTE: the password is an ordinary register bank, not a RAM, so it
      // is reset explicitly; any reset must restore the factory password.
      pw_q     <= DEFAULT_PW;
      fail_q   <= '0;
      key_prev <= KEY_NONE;
      key_ack  <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      cursor_q <= cursor_d;
      pw_q     <= pw_d;
      fail_q   <= fail_d;
      key_prev <= key_code;
      key_ack  <= ack_d;
    end
  end

  assign entry_bcd = entry_q;
  assign cursor    = cursor_q;
  assign unlock    = (state_q == ST_OPEN);
  assign error     = (state_q == ST_FAIL);
  assign lockout   = (state_q == ST_LOCKOUT);
  assign prog_mode = (state_q == ST_SET);

endmodule

// File: tb/tb_doorlock_keypad_ctrl.sv
// Bench for doorlock_keypad_ctrl: directed scenarios plus random key
// traffic, all compared cycle by cycle against a behavioural model that
// tracks mode, remaining dwell and digits as plain integers.
module tb_doorlock_keypad_ctrl;

  localparam int          DIGITS    = 4;
  localparam int          DIGIT_MAX = 9;
  localparam int          MAX_FAIL  = 3;
  localparam int          UNLOCK    = 20;
  localparam int          ERR       = 10;
  localparam int          LOCK      = 50;
  localparam logic [15:0] PW0       = 16'h1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_code = 4'd0;
  logic [15:0] entry_bcd;
  logic [2:0]  cursor;
  logic        unlock, error, lockout, prog_mode, key_ack;

  always #4 clk = ~clk;

  doorlock_keypad_ctrl #(
    .DIGITS        (DIGITS),
    .DIGIT_MAX     (DIGIT_MAX),
    .DEFAULT_PW    (PW0),
    .MAX_FAIL      (MAX_FAIL),
    .UNLOCK_CYCLES (UNLOCK),
    .ERR_CYCLES    (ERR),
    .LOCK_CYCLES   (LOCK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .entry_bcd (entry_bcd),
    .cursor    (cursor),
    .unlock    (unlock),
    .error     (error),
    .lockout   (lockout),
    .prog_mode (prog_mode),
    .key_ack   (key_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_ENTRY, M_CHECK, M_OPEN, M_FAIL, M_LOCK, M_SET} mode_t;
  mode_t m_mode;
  int    m_dwell;            // cycles left in a timed mode, including this one
  int    m_dig[DIGITS];
  int    m_pw[DIGITS];
  int    m_cur;
  int    m_fails;
  int    m_prev;
  bit    m_ack;

  function automatic void m_clear();
    for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
    m_cur = 0;
  endfunction

  function automatic void m_reset();
    m_mode  = M_ENTRY;
    m_dwell = 0;
    m_fails = 0;
    m_prev  = 0;
    m_ack   = 0;
    m_clear();
    for (int i = 0; i < DIGITS; i++) m_pw[i] = int'((PW0 >> (4 * i)) & 16'hF);
  endfunction

  function automatic bit m_match();
    for (int i = 0; i < DIGITS; i++) if (m_dig[i] != m_pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_step(input int k);
    bit evt;
    evt    = (k != 0) && (k != m_prev);
    m_prev = k;
    m_ack  = 0;
    case (m_mode)
      M_ENTRY, M_SET: begin
        if (evt) begin
          if (k == 2) begin
            m_dig[m_cur] = (m_dig[m_cur] + 1) % (DIGIT_MAX + 1);
            m_ack = 1;
          end else if (k == 1) begin
            m_cur = (m_cur + 1) % DIGITS;
            m_ack = 1;
          end else if (k == 11) begin
            m_ack = 1;
            if (m_mode == M_ENTRY) m_mode = M_CHECK;
            else begin
              m_pw   = m_dig;
              m_mode = M_ENTRY;
              m_clear();
            end
          end else if (k == 12) begin
            m_ack  = 1;
            m_mode = M_ENTRY;
            m_clear();
          end
        end
      end
      M_CHECK: begin
        if (m_match()) begin
          m_mode = M_OPEN; m_dwell = UNLOCK; m_fails = 0;
        end else if (m_fails + 1 == MAX_FAIL) begin
          m_mode = M_LOCK; m_dwell = LOCK;
        end else begin
          m_fails++; m_mode = M_FAIL; m_dwell = ERR;
        end
      end
      M_OPEN: begin
        if (m_dwell == 1) begin
          m_mode = M_ENTRY; m_clear();
        end else begin
          m_dwell--;
          if (evt && k == 11) begin
            m_ack = 1; m_mode = M_ENTRY; m_clear();
          end else if (evt && k == 12) begin
            m_ack = 1; m_mode = M_SET; m_clear();
          end
        end
      end
      default: begin // M_FAIL, M_LOCK
        if (m_dwell == 1) begin
          if (m_mode == M_LOCK) m_fails = 0;
          m_mode = M_ENTRY; m_clear();
        end else begin
          m_dwell--;
        end
      end
    endcase
  endfunction

  function automatic logic [15:0] m_entry();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'(m_dig[i]);
    return v;
  endfunction

  function automatic logic [15:0] m_pw_packed();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'(m_pw[i]);
    return v;
  endfunction

  task automatic compare_all();
    check("entry_bcd", 32'(entry_bcd), 32'(m_entry()));
    check("cursor",    32'(cursor),    32'(m_cur));
    check("unlock",    32'(unlock),    32'(m_mode == M_OPEN));
    check("error",     32'(error),     32'(m_mode == M_FAIL));
    check("lockout",   32'(lockout),   32'(m_mode == M_LOCK));
    check("prog_mode", 32'(prog_mode), 32'(m_mode == M_SET));
    check("key_ack",   32'(key_ack),   32'(m_ack));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    m_step(int'(key_code));
    #1;
    compare_all();
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    key_code = k;
    repeat (hold) tick();
    key_code = 4'd0;
    tick();
  endtask

  // Types a code starting from a cleared entry, then presses A
  task automatic enter_code(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 0; i < DIGITS; i++) begin
      repeat (int'(c[4*i +: 4])) press(4'd2, 1);
      if (i < DIGITS - 1) press(4'd1, 1);
    end
    press(4'd11, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_code = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, acks;
    logic [3:0] k;

    // Reset state
    do_reset();
    check("rst_entry", 32'(entry_bcd), 32'h0);
    check("rst_flags", 32'({unlock, error, lockout, prog_mode, key_ack}), 32'h0);
    tick();

    // 1: correct default code unlocks for exactly UNLOCK cycles
    enter_code(PW0);
    n = unlock ? 1 : 0;
    repeat (UNLOCK + 10) begin tick(); if (unlock) n++; end
    check("s1_open_len", 32'(n), 32'(UNLOCK));
    check("s1_entry_clr", 32'(entry_bcd), 32'h0);

    // 2: held INC gives one event; ten INC events wrap the digit
    key_code = 4'd2;
    acks = 0;
    repeat (100) begin tick(); acks += int'(key_ack); end
    key_code = 4'd0;
    tick();
    check("s2_one_ack", 32'(acks), 32'd1);
    check("s2_digit1", 32'(entry_bcd[3:0]), 32'd1);
    press(4'd12, 1);
    repeat (9) press(4'd2, 1);
    check("s2_digit9", 32'(entry_bcd[3:0]), 32'd9);
    press(4'd2, 1);
    check("s2_wrap", 32'(entry_bcd[3:0]), 32'd0);
    press(4'd12, 1);

    // 3: three wrong attempts -> two errors then a lockout that ignores keys
    for (int r = 0; r < 2; r++) begin
      enter_code(16'h0001);
      n = error ? 1 : 0;
      repeat (ERR + 5) begin tick(); if (error) n++; end
      check("s3_err_len", 32'(n), 32'(ERR));
    end
    enter_code(16'h0001);
    n = lockout ? 1 : 0;
    acks = 0;
    for (int i = 0; i < LOCK + 10; i++) begin
      if (lockout) key_code = (i % 3 == 0) ? 4'd11 : ((i % 3 == 1) ? 4'd2 : 4'd0);
      else key_code = 4'd0;
      tick();
      if (lockout) n++;
      acks += int'(key_ack);
    end
    key_code = 4'd0;
    tick();
    check("s3_lock_len", 32'(n), 32'(LOCK));
    check("s3_lock_noack", 32'(acks), 32'd0);
    enter_code(16'h0001);
    check("s3_failcnt_clr", 32'({error, lockout}), 32'b10);
    repeat (ERR + 2) tick();

    // 4: reprogram the password while open
    enter_code(PW0);
    check("s4_open", 32'(unlock), 32'd1);
    press(4'd12, 1);
    check("s4_set", 32'(prog_mode), 32'd1);
    enter_code(16'h0987);
    check("s4_set_exit", 32'(prog_mode), 32'd0);
    enter_code(PW0);
    check("s4_old_rejected", 32'(error), 32'd1);
    repeat (ERR + 2) tick();
    enter_code(16'h0987);
    check("s4_new_accepted", 32'(unlock), 32'd1);

    // 5: key edge on the cycle the OPEN timer expires is dropped
    for (int i = 0; i < UNLOCK + 5 && !(m_mode == M_OPEN && m_dwell == 1); i++) tick();
    check("s5_last_open", 32'(unlock), 32'd1);
    key_code = 4'd11;
    tick();
    check("s5_no_ack", 32'(key_ack), 32'd0);
    check("s5_entry", 32'({unlock, prog_mode}), 32'd0);
    key_code = 4'd0;
    tick();

    // 6: asynchronous reset in the middle of SET restores the default password
    enter_code(16'h0987);
    press(4'd12, 1);
    press(4'd2, 1);
    press(4'd2, 1);
    #2;
    rst = 1'b1;
    #1;
    check("s6_async", 32'({entry_bcd, cursor, unlock, error, lockout, prog_mode, key_ack}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    rst = 1'b0;
    tick();
    enter_code(PW0);
    check("s6_pw_default", 32'(unlock), 32'd1);

    // Random traffic against the model
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: k = 4'd2;
        3, 4:    k = 4'd1;
        5:       k = 4'd11;
        6:       k = 4'd12;
        7:       k = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(3, 10)) : 4'($urandom_range(13, 15));
        8:       k = 4'd0;
        default: k = 4'd15;
      endcase
      if (k == 4'd15 && m_mode == M_ENTRY) begin
        press(4'd12, 1);
        enter_code(m_pw_packed());
      end else begin
        key_code = k;
        repeat ($urandom_range(1, 3)) tick();
        if ($urandom_range(0, 1) == 0) begin
          key_code = 4'd0;
          tick();
        end
      end
    end
    key_code = 4'd0;
    repeat (LOCK + 5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
